// File: rtl/if_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_unit
//  Purpose  : Instruction fetch unit. Keeps one read outstanding to
//             instruction memory, holds fetched words in a two-entry buffer
//             for decode, and handles redirect, stop and halt.
//  Revision : 1.0 - initial release
// ============================================================================
module if_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic [15:0] i_reg,
  output logic [15:0] i_pc,
  output logic        i_valid,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stop,
  output logic        halted
);

  localparam logic [1:0] c_ST_FETCH   = 2'd0;
  localparam logic [1:0] c_ST_DISCARD = 2'd1;
  localparam logic [1:0] c_ST_HALT    = 2'd2;
  localparam logic [1:0] c_DEPTH      = 2'(BUF_DEPTH);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [15:0] r_pc;
  logic [15:0] r_addr;
  logic        r_outst;
  logic [1:0]  r_cnt;
  logic [15:0] r_d0, r_p0, r_d1, r_p1;

  logic        w_ack, w_hold, w_flush, w_pop, w_push;
  logic [1:0]  w_cnt_next, w_occ;
  logic [15:0] w_pc_next;
  logic        w_outst_next;

  // An ack only counts when it answers our own outstanding request; the
  // request stays held (same address) until that ack arrives.
  assign w_ack   = mem_ack & r_outst;
  assign w_hold  = r_outst & ~mem_ack;
  assign w_flush = redirect | stop;
  assign w_pop   = (r_cnt != 2'd0) & id_ready & ~w_flush;
  assign w_push  = w_ack & (r_state == c_ST_FETCH) & ~w_flush;
  assign w_occ   = r_cnt - {1'b0, w_pop};

  // Next buffer count, fetch pointer and request flag
  always_comb begin
    w_cnt_next = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    if (w_flush) begin
      w_cnt_next = 2'd0;
    end
    w_pc_next = r_pc;
    if (redirect) begin
      w_pc_next = redirect_pc;
    end else if (w_push) begin
      w_pc_next = r_pc + 16'd1;
    end
    w_outst_next = w_hold |
                   ((w_state_next == c_ST_FETCH) & (w_cnt_next < c_DEPTH));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: redirect beats stop; a pending ack forces DISCARD
  always_comb begin
    w_state_next = r_state;
    if (redirect) begin
      w_state_next = w_hold ? c_ST_DISCARD : c_ST_FETCH;
    end else if (stop) begin
      w_state_next = c_ST_HALT;
    end else if ((r_state == c_ST_DISCARD) && w_ack) begin
      w_state_next = c_ST_FETCH;
    end
  end

  // FSM outputs
  always_comb begin
    halted = (r_state == c_ST_HALT);
  end

  // Fetch pointer, request tracking and two-entry buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_outst <= 1'b0;
      r_cnt   <= 2'd0;
      r_d0    <= 16'd0;
      r_p0    <= 16'd0;
      r_d1    <= 16'd0;
      r_p1    <= 16'd0;
    end else begin
      r_pc    <= w_pc_next;
      r_outst <= w_outst_next;
      r_cnt   <= w_cnt_next;
      // Address is captured only when a fresh request is launched
      if (!w_hold) begin
        r_addr <= w_pc_next;
      end
      if (w_pop) begin
        r_d0 <= r_d1;
        r_p0 <= r_p1;
      end
      // Push lands in the first free slot after any same-cycle pop
      if (w_push) begin
        if (w_occ == 2'd0) begin
          r_d0 <= mem_data;
          r_p0 <= r_addr;
        end else begin
          r_d1 <= mem_data;
          r_p1 <= r_addr;
        end
      end
    end
  end

  assign mem_req  = r_outst;
  assign mem_addr = r_addr;
  assign i_valid  = (r_cnt != 2'd0);
  assign i_reg    = r_d0;
  assign i_pc     = r_p0;

endmodule
`default_nettype wire

// File: tb/tb_if_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_unit
//  Purpose  : Self-checking bench for if_unit with a latency-programmable
//             memory responder and a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_unit;

  localparam logic [15:0] c_RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, mem_req, mem_ack, id_ready, redirect, stop, halted, i_valid;
  logic [15:0] mem_addr, mem_data, i_reg, i_pc, redirect_pc;

  always #5 clk = ~clk;

  if_unit #(.RESET_PC(c_RESET_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .i_reg(i_reg), .i_pc(i_pc),
    .i_valid(i_valid), .id_ready(id_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .stop(stop), .halted(halted)
  );

  typedef struct packed { logic [15:0] pc; logic [15:0] data; } ent_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus controls for the current cycle
  logic        t_rst, t_ready, t_redir, t_stop;
  logic [15:0] t_rpc;
  int          lat, mem_wait;

  // Reference model: buffer contents, fetch pointer, request, mode
  ent_t        m_q[$];
  logic [15:0] m_pc, m_addr;
  bit          m_out;
  int          m_mode;   // 0 fetching, 1 dropping a stale ack, 2 halted

  // Words handed to decode, in order
  logic [15:0] got[$];
  logic [15:0] gotd[$];

  function automatic logic [15:0] img(input logic [15:0] a);
    return a ^ 16'hBEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? {16'd0, got[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] gotd_at(input int i);
    return (i < gotd.size()) ? {16'd0, gotd[i]} : 32'hFFFF_FFFF;
  endfunction

  // One clock: drive inputs, advance model, then compare at the next negedge
  task automatic step();
    logic ack;
    bit   held;
    ent_t e;
    if (t_rst) begin
      ack = mem_req;        // memory answers even during reset; must be dropped
      mem_wait = 0;
    end else if (mem_req) begin
      if (mem_wait >= lat) begin ack = 1'b1; mem_wait = 0; end
      else begin ack = 1'b0; mem_wait++; end
    end else begin
      ack = 1'b0;
      mem_wait = 0;
    end
    mem_ack     = ack;
    mem_data    = ack ? img(mem_addr) : 16'h0BAD;
    rst         = t_rst;
    id_ready    = t_ready;
    redirect    = t_redir;
    redirect_pc = t_rpc;
    stop        = t_stop;
    if (!t_rst && !t_redir && !t_stop && i_valid && t_ready) begin
      got.push_back(i_pc);
      gotd.push_back(i_reg);
    end

    held = m_out && !ack;
    if (t_rst) begin
      m_q.delete();
      m_pc   = c_RESET_PC;
      m_mode = 0;
      m_out  = 0;
    end else begin
      if (t_redir) begin
        m_q.delete();
        m_pc   = t_rpc;
        m_mode = held ? 1 : 0;
      end else if (t_stop) begin
        m_q.delete();
        m_mode = 2;
      end else begin
        if (m_q.size() > 0 && t_ready) m_q.delete(0);
        if (m_out && ack) begin
          if (m_mode == 0) begin
            e.pc = m_addr;
            e.data = img(m_addr);
            m_q.push_back(e);
            m_pc = m_pc + 16'd1;
          end else if (m_mode == 1) begin
            m_mode = 0;
          end
        end
      end
      if (held) m_out = 1;
      else if (m_mode == 0 && m_q.size() < 2) begin
        m_out  = 1;
        m_addr = m_pc;
      end else m_out = 0;
    end

    @(negedge clk);
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_out});
    if (m_out) chk("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
    chk("i_valid", {31'd0, i_valid}, (m_q.size() > 0) ? 32'd1 : 32'd0);
    if (m_q.size() > 0) begin
      chk("i_pc", {16'd0, i_pc}, {16'd0, m_q[0].pc});
      chk("i_reg", {16'd0, i_reg}, {16'd0, m_q[0].data});
    end
    chk("halted", {31'd0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'd0;
    stop = 1'b0; mem_ack = 1'b0; mem_data = 16'd0;
    t_rst = 1'b1; t_ready = 1'b0; t_redir = 1'b0; t_stop = 1'b0; t_rpc = 16'd0;
    lat = 0; mem_wait = 0;
    m_out = 0; m_mode = 0; m_pc = c_RESET_PC; m_addr = c_RESET_PC;
    @(negedge clk);

    // Reset state
    step(); step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_i_valid", {31'd0, i_valid}, 32'd0);
    chk("rst_halted",  {31'd0, halted},  32'd0);
    chk("rst_i_reg",   {16'd0, i_reg},   32'd0);
    chk("rst_i_pc",    {16'd0, i_pc},    32'd0);

    // Streaming, single-cycle memory
    t_rst = 1'b0; t_ready = 1'b1; lat = 0;
    step();
    chk("first_req_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, c_RESET_PC});
    got.delete(); gotd.delete();
    repeat (7) step();
    for (int i = 0; i < 4; i++) chk("stream_pc", got_at(i), i);
    chk("stream_data1", gotd_at(1), 32'h0000_BEEE);

    // Backpressure: buffer fills to two and fetch stops
    t_ready = 1'b0;
    repeat (6) step();
    chk("bp_i_valid", {31'd0, i_valid}, 32'd1);
    chk("bp_mem_req", {31'd0, mem_req}, 32'd0);
    chk("bp_head_pc", {16'd0, i_pc}, 32'h0000_0006);
    got.delete(); gotd.delete();
    t_ready = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 4; i++) chk("bp_release_pc", got_at(i), 6 + i);

    // Redirect while a slow request is pending
    lat = 3;
    step();
    chk("pend_mem_req", {31'd0, mem_req}, 32'd1);
    t_redir = 1'b1; t_rpc = 16'h0040;
    step();
    t_redir = 1'b0;
    chk("redir_flush", {31'd0, i_valid}, 32'd0);
    got.delete(); gotd.delete();
    repeat (14) step();
    chk("redir_pc",   got_at(0),  32'h0000_0040);
    chk("redir_data", gotd_at(0), 32'h0000_BEAF);
    chk("redir_pc2",  got_at(1),  32'h0000_0041);

    // Wrap of the fetch pointer
    lat = 0;
    t_redir = 1'b1; t_rpc = 16'hFFFF;
    step();
    t_redir = 1'b0;
    got.delete(); gotd.delete();
    repeat (8) step();
    chk("wrap_pc0", got_at(0), 32'h0000_FFFF);
    chk("wrap_pc1", got_at(1), 32'h0000_0000);
    chk("wrap_pc2", got_at(2), 32'h0000_0001);
    chk("wrap_data0", gotd_at(0), 32'h0000_4110);

    // Stop, stay halted, then redirect resumes fetch
    t_stop = 1'b1;
    step();
    t_stop = 1'b0;
    repeat (5) begin
      step();
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_no_req", {31'd0, mem_req}, 32'd0);
    end
    t_redir = 1'b1; t_rpc = 16'h0010;
    step();
    t_redir = 1'b0;
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0010});
    got.delete(); gotd.delete();
    repeat (6) step();
    chk("resume_pc",   got_at(0),  32'h0000_0010);
    chk("resume_data", gotd_at(0), 32'h0000_BEFF);

    // Reset in the middle of a slow request
    lat = 3;
    begin
      int budget = 10;
      step();
      while (!(mem_req && mem_wait > 0) && budget > 0) begin
        step();
        budget--;
      end
      chk("rst_wait_req", (budget > 0) ? 32'd1 : 32'd0, 32'd1);
    end
    t_rst = 1'b1;
    step();
    t_rst = 1'b0;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_i_valid", {31'd0, i_valid}, 32'd0);
    step();
    chk("midrst_refetch", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, c_RESET_PC});
    got.delete(); gotd.delete();
    repeat (8) step();
    chk("midrst_pc0", got_at(0), 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_unit.md
IF_UNIT -- requirements
Module: if_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000; word address of the first fetch after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2; instruction buffer entries, fixed at 2 in this version.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  instruction memory read request.
REQ-006 SHALL have port mem_addr  output  16  word address of the request.
REQ-007 SHALL have port mem_ack  input  1  read completion; mem_data valid in the same cycle.
REQ-008 SHALL have port mem_data  input  16  fetched instruction word.
REQ-009 SHALL have port i_reg  output  16  instruction at buffer head, driven to id_unit.
REQ-010 SHALL have port i_pc  output  16  word address of i_reg.
REQ-011 SHALL have port i_valid  output  1  buffer non-empty, i_reg/i_pc meaningful.
REQ-012 SHALL have port id_ready  input  1  decode consumes head when high with i_valid.
REQ-013 SHALL have port redirect  input  1  control transfer: flush and refetch.
REQ-014 SHALL have port redirect_pc  output-of-execute, input  16  target word address, sampled when redirect=1.
REQ-015 SHALL have port stop  input  1  decoded STOP accepted, halts fetch.
REQ-016 SHALL have port halted  output  1  fetch unit in HALT state.

Function
REQ-017 SHALL keep fetch pointer pc (16 bit); pc increments by 1 on each kept ack, wrapping 16'hFFFF -> 16'h0000.
REQ-018 SHALL allow at most one outstanding request; mem_req and mem_addr stay stable from assertion until the cycle mem_ack=1.
REQ-019 SHALL assert a new mem_req only when state is FETCH and (entries + outstanding) < 2; back-to-back: new request may assert the cycle after ack.
REQ-020 SHALL push {mem_data, mem_addr} into the buffer on ack in FETCH; push and pop in the same cycle both occur, count unchanged.
REQ-021 SHALL pop the head when i_valid & id_ready; i_reg/i_pc are registered buffer head, no combinational path mem_data -> i_reg.
REQ-022 SHALL implement states FETCH, DISCARD, HALT; transitions: FETCH -redirect w/ outstanding-> DISCARD; DISCARD -ack-> FETCH; any -stop-> HALT (DISCARD-equivalent drop of pending ack); HALT -redirect-> FETCH (or DISCARD if ack still pending).
REQ-023 SHALL on redirect: flush buffer same cycle (i_valid=0 next cycle), load pc <= redirect_pc, drop any in-flight ack data.
REQ-024 SHALL give priority redirect > stop > pop/push when asserted simultaneously.
REQ-025 SHALL in HALT issue no requests, keep buffer empty, drive halted=1.
REQ-026 SHALL first redirected fetch present mem_addr = redirect_pc no earlier than the cycle after redirect (or after discarded ack).

Reset
REQ-027 SHALL on rst=1 at clock edge: pc <= RESET_PC, buffer empty, state FETCH, outstanding cleared, mem_req=0, i_valid=0, halted=0, i_reg=0, i_pc=0.
REQ-028 SHALL on rst mid-request abandon the transaction; memory ignores an ack arriving during or after reset for the abandoned request (ack while rst=1 is dropped).
REQ-029 SHALL issue first request with mem_addr=RESET_PC in the first cycle after rst deasserts.

Verification
REQ-030 SHALL cover streaming: memory acks every request in 1 cycle, id_ready=1 -> i_pc sequence 0,1,2,3, i_reg matches mem image, no gaps after fill.
REQ-031 SHALL cover backpressure: id_ready=0 for 6 cycles -> exactly 2 entries held, mem_req stays 0, no lost or duplicated words on release.
REQ-032 SHALL cover redirect with pending request (ack delayed 3 cycles), redirect_pc=16'h0040 -> old data dropped, next i_valid shows i_pc=16'h0040.
REQ-033 SHALL cover wrap: redirect_pc=16'hFFFF -> i_pc sequence FFFF, 0000, 0001.
REQ-034 SHALL cover stop then redirect_pc=16'h0010 -> halted=1, no mem_req while halted, fetch resumes at 0010, halted=0.
REQ-035 SHALL cover rst asserted while mem_req=1 -> next cycle mem_req=0, i_valid=0, then fetch at RESET_PC.
